// File: rtl/mlp_mv_pkg.sv
// ----------------------------------------------------------------------------
// mlp_mv_pkg : shared types and widths for the matrix-vector MLP sequencer
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mlp_mv_pkg;

  localparam int W_VEC  = 128;
  localparam int W_HALF = 64;
  localparam int W_SUM  = 48;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    GAP     = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } t_mv_state;

endpackage

`default_nettype wire

// File: rtl/mlp_mv_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// mlp_mv_seq_ctrl_if : job, vector, cascade and result signals of the sequencer
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mlp_mv_seq_ctrl_if
  import mlp_mv_pkg::*;
#(
  parameter int RW = 10,
  parameter int AW = 11
) ();

  logic              i_start;
  logic [RW-1:0]     i_num_rows;
  logic [AW-1:0]     i_bram_base;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [W_VEC-1:0]  i_vec_data;
  logic              i_vec_valid;
  logic              o_vec_ready;
  logic [W_HALF-1:0] o_wrdata;
  logic [W_HALF-1:0] o_bram_din2mlp;
  logic              o_first;
  logic              o_last;
  logic              o_pause;
  logic              o_bram_rden;
  logic [AW-1:0]     o_bram_rdaddr;
  logic              o_read;
  logic [W_SUM-1:0]  i_sum;
  logic              i_valid;
  logic [W_SUM-1:0]  o_res;
  logic              o_res_valid;
  logic              i_res_ready;

  modport master (
    input  i_start, i_num_rows, i_bram_base, i_vec_data, i_vec_valid,
           i_sum, i_valid, i_res_ready,
    output o_busy, o_done, o_err, o_vec_ready, o_wrdata, o_bram_din2mlp,
           o_first, o_last, o_pause, o_bram_rden, o_bram_rdaddr, o_read,
           o_res, o_res_valid
  );

  modport slave (
    output i_start, i_num_rows, i_bram_base, i_vec_data, i_vec_valid,
           i_sum, i_valid, i_res_ready,
    input  o_busy, o_done, o_err, o_vec_ready, o_wrdata, o_bram_din2mlp,
           o_first, o_last, o_pause, o_bram_rden, o_bram_rdaddr, o_read,
           o_res, o_res_valid
  );

endinterface

`default_nettype wire

// File: rtl/mlp_mv_res_fifo.sv
// ----------------------------------------------------------------------------
// mlp_mv_res_fifo : synchronous result FIFO with occupancy count
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mlp_mv_res_fifo
  import mlp_mv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = W_SUM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // Head is forced to zero when empty so the output is defined out of reset.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mlp_mv_seq_ctrl.sv
// ----------------------------------------------------------------------------
// mlp_mv_seq_ctrl : vector load + credit-throttled row compute sequencer
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mlp_mv_seq_ctrl
  import mlp_mv_pkg::*;
#(
  parameter int M        = 6,
  parameter int RW       = 10,
  parameter int AW       = 11,
  parameter int FDEPTH   = 8,
  parameter int LOAD_GAP = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mlp_mv_seq_ctrl_if.master bus
);

  localparam int NW  = 2 * M;
  localparam int WCW = $clog2(NW);
  localparam int GW  = $clog2(LOAD_GAP + 2);
  localparam int CW  = $clog2(FDEPTH) + 1;

  t_mv_state         state;
  t_mv_state         state_nxt;
  logic [WCW-1:0]    wc;
  logic [GW-1:0]     gc;
  logic [RW-1:0]     row;
  logic [RW-1:0]     num_rows_q;
  logic [RW-1:0]     res_cnt;
  logic              half;
  logic [AW-1:0]     base_q;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [W_SUM-1:0]  fifo_dout;
  logic              done_nxt;
  logic              done_q;
  logic              err_q;
  logic              vec_ready;
  logic              issue;
  logic              row_start;
  logic [W_HALF-1:0] wrdata_q;
  logic [W_HALF-1:0] din2mlp_q;
  logic              first_q;
  logic              last_q;
  logic              pause_q;
  logic              accept;
  logic              rx_phase;
  logic              push;
  logic              pop;
  logic              stray;
  logic              dec;
  logic              has_credit;
  logic              start_job;

  assign accept     = bus.i_vec_valid & vec_ready;
  assign rx_phase   = (state == COMPUTE) || (state == DRAIN);
  assign push       = bus.i_valid & rx_phase & ~fifo_full;
  assign pop        = bus.i_res_ready & ~fifo_empty;
  assign stray      = bus.i_valid & ~push;
  assign dec        = bus.i_valid & rx_phase & (outstanding != '0);
  // Results already queued plus rows in flight must never exceed FIFO space.
  assign has_credit = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FDEPTH);
  assign start_job  = (state == IDLE) & bus.i_start & (bus.i_num_rows != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    vec_ready = 1'b0;
    issue     = 1'b0;
    row_start = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_num_rows == '0) done_nxt  = 1'b1;
          else                      state_nxt = LOAD;
        end
      end
      LOAD: begin
        vec_ready = 1'b1;
        if (accept && (wc == WCW'(NW - 1))) state_nxt = GAP;
      end
      GAP: begin
        if (gc == GW'(LOAD_GAP)) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (half) begin
          issue = 1'b1;
          if (row == num_rows_q - RW'(1)) state_nxt = DRAIN;
        end else if (has_credit) begin
          issue     = 1'b1;
          row_start = 1'b1;
        end
      end
      DRAIN: begin
        if (res_cnt == num_rows_q) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wc          <= '0;
      gc          <= '0;
      row         <= '0;
      half        <= 1'b0;
      num_rows_q  <= '0;
      base_q      <= '0;
      res_cnt     <= '0;
      outstanding <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wrdata_q    <= '0;
      din2mlp_q   <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      done_q <= done_nxt;

      if (stray)                                err_q <= 1'b1;
      else if ((state == IDLE) && bus.i_start)  err_q <= 1'b0;

      if (start_job) begin
        num_rows_q <= bus.i_num_rows;
        base_q     <= bus.i_bram_base;
        wc         <= '0;
        gc         <= '0;
        row        <= '0;
        half       <= 1'b0;
        res_cnt    <= '0;
      end

      if (accept) wc <= (wc == WCW'(NW - 1)) ? '0 : wc + WCW'(1);
      if (state == GAP) gc <= gc + GW'(1);

      if (issue) begin
        half <= ~half;
        if (half) row <= row + RW'(1);
      end

      outstanding <= outstanding + CW'(row_start) - CW'(dec);
      if (push) res_cnt <= res_cnt + RW'(1);

      // Write port: data held through bubbles once the first word went out.
      if (accept) begin
        wrdata_q  <= bus.i_vec_data[W_HALF-1:0];
        din2mlp_q <= bus.i_vec_data[W_VEC-1:W_HALF];
        first_q   <= (wc == '0);
        last_q    <= (wc == WCW'(NW - 1));
        pause_q   <= 1'b0;
      end else if ((state == LOAD) && (wc != '0)) begin
        first_q   <= 1'b0;
        last_q    <= 1'b0;
        pause_q   <= 1'b1;
      end else begin
        wrdata_q  <= '0;
        din2mlp_q <= '0;
        first_q   <= 1'b0;
        last_q    <= 1'b0;
        pause_q   <= 1'b0;
      end
    end
  end

  mlp_mv_res_fifo #(
    .DEPTH (FDEPTH),
    .W     (W_SUM)
  ) u_res_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (push),
    .din   (bus.i_sum),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign bus.o_busy         = (state != IDLE);
  assign bus.o_done         = done_q;
  assign bus.o_err          = err_q;
  assign bus.o_vec_ready    = vec_ready;
  assign bus.o_wrdata       = wrdata_q;
  assign bus.o_bram_din2mlp = din2mlp_q;
  assign bus.o_first        = first_q;
  assign bus.o_last         = last_q;
  assign bus.o_pause        = pause_q;
  assign bus.o_read         = issue;
  assign bus.o_bram_rden    = issue;
  assign bus.o_bram_rdaddr  = issue ? (base_q + AW'({row, half})) : '0;
  assign bus.o_res          = fifo_dout;
  assign bus.o_res_valid    = ~fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_mlp_mv_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mlp_mv_seq_ctrl : directed self-checking bench with a small cascade model
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mlp_mv_seq_ctrl;

  localparam int M        = 6;
  localparam int RW       = 10;
  localparam int AW       = 11;
  localparam int FDEPTH   = 4;
  localparam int LOAD_GAP = 3;
  localparam int NW       = 2 * M;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  mlp_mv_seq_ctrl_if #(.RW(RW), .AW(AW)) bus ();

  mlp_mv_seq_ctrl #(
    .M(M), .RW(RW), .AW(AW), .FDEPTH(FDEPTH), .LOAD_GAP(LOAD_GAP)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [196:0] outs;
  assign outs = {bus.o_busy, bus.o_done, bus.o_err, bus.o_vec_ready, bus.o_wrdata,
                 bus.o_bram_din2mlp, bus.o_first, bus.o_last, bus.o_pause,
                 bus.o_bram_rden, bus.o_bram_rdaddr, bus.o_read, bus.o_res, bus.o_res_valid};

  function automatic logic [127:0] word(input int w);
    return {64'hB000_0000_0000_0000 + 64'(w), 64'hA000_0000_0000_0000 + 64'(w)};
  endfunction

  function automatic logic [47:0] exp_sum(input int r);
    return 48'h0ABC_0000_0000 + 48'(r) * 48'h0101;
  endfunction

  // Cascade model: one result per row, 3 cycles after the row's second read.
  bit          model_en;
  int          model_row;
  bit          rd_half;
  int          mcyc;
  int          pipe_due [$];
  logic [47:0] pipe_sum [$];

  initial begin
    mcyc = 0;
    forever begin
      @(negedge clk);
      if (model_en) begin
        if (pipe_due.size() > 0 && pipe_due[0] <= mcyc) begin
          bus.i_valid = 1'b1;
          bus.i_sum   = pipe_sum.pop_front();
          void'(pipe_due.pop_front());
        end else begin
          bus.i_valid = 1'b0;
          bus.i_sum   = '0;
        end
        if (bus.o_read) begin
          if (rd_half) begin
            pipe_due.push_back(mcyc + 3);
            pipe_sum.push_back(exp_sum(model_row));
            model_row++;
          end
          rd_half = !rd_half;
        end
      end
      mcyc++;
    end
  end

  // Job recording
  int          nw, pause_cnt, first_cnt, last_cnt, first_idx, last_idx, last_cyc;
  bit          hold_bad;
  logic [63:0] wr_lo [16];
  logic [63:0] wr_hi [16];
  logic [63:0] last_wr;
  int          nrd, first_rd_cyc, reads_before, npop, done_cnt;
  logic [10:0] rd_addr [64];
  int          rd_cyc [64];
  logic [47:0] popped [64];
  bit          err_seen, err_at_start, timed_out, poked, finished;

  task automatic run_job(input int n, input logic [10:0] base, input int pat,
                         input int ready_cyc, input bit poke, input int max_cyc);
    int wi;
    nw = 0; pause_cnt = 0; first_cnt = 0; last_cnt = 0; first_idx = -1; last_idx = -1;
    last_cyc = -1; hold_bad = 0; last_wr = '0; nrd = 0; first_rd_cyc = -1;
    reads_before = 0; npop = 0; done_cnt = 0; err_seen = 0; timed_out = 0;
    poked = 0; finished = 0; wi = 0;
    model_row = 0; rd_half = 0;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_num_rows = RW'(n); bus.i_bram_base = base;
    @(negedge clk);
    bus.i_start = 1'b0;
    err_at_start = bus.o_err;
    for (int cyc = 0; cyc <= max_cyc; cyc++) begin
      bus.i_start = 1'b0;
      if (bus.o_pause) begin
        pause_cnt++;
        if (bus.o_wrdata != last_wr) hold_bad = 1;
      end else if (bus.o_wrdata != '0) begin
        if (nw < 16) begin wr_lo[nw] = bus.o_wrdata; wr_hi[nw] = bus.o_bram_din2mlp; end
        if (bus.o_first) begin first_cnt++; first_idx = nw; end
        if (bus.o_last)  begin last_cnt++; last_idx = nw; last_cyc = cyc; end
        last_wr = bus.o_wrdata;
        nw++;
      end
      if (bus.o_read) begin
        if (nrd < 64) begin rd_addr[nrd] = bus.o_bram_rdaddr; rd_cyc[nrd] = cyc; end
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        nrd++;
        if (cyc < ready_cyc) reads_before++;
        if (poke && !poked) begin bus.i_start = 1'b1; bus.i_num_rows = RW'(7); poked = 1; end
      end
      if (bus.o_done) done_cnt++;
      if (bus.o_err) err_seen = 1;
      bus.i_res_ready = (cyc >= ready_cyc);
      if (bus.i_res_ready && bus.o_res_valid) begin
        if (npop < 64) popped[npop] = bus.o_res;
        npop++;
      end
      if (wi < NW && (pat == 0 || cyc % 3 == 0)) begin
        bus.i_vec_valid = 1'b1;
        bus.i_vec_data  = word(wi);
        if (bus.o_vec_ready) wi++;
      end else begin
        bus.i_vec_valid = 1'b0;
      end
      @(negedge clk);
      if (done_cnt > 0 && npop >= n) begin finished = 1; break; end
    end
    timed_out = !finished;
    bus.i_res_ready = 1'b0; bus.i_vec_valid = 1'b0; bus.i_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (outs !== '0) begin tests_failed++; $display("FAIL reset_held outs=%h exp=0", outs); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (outs !== '0) begin tests_failed++; $display("FAIL reset_release outs=%h exp=0", outs); end
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_num_rows = RW'(4); bus.i_bram_base = 11'h040;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int w = 0; w < 5; w++) begin
      bus.i_vec_valid = 1'b1; bus.i_vec_data = word(w);
      @(negedge clk);
    end
    tests_run++;
    if (bus.o_busy !== 1'b1 || bus.o_wrdata !== word(4)[63:0]) begin
      tests_failed++; $display("FAIL midload_pre busy=%b wr=%h exp busy=1 wr=%h", bus.o_busy, bus.o_wrdata, word(4)[63:0]);
    end
    rst = 1'b1; bus.i_vec_data = word(5);
    @(negedge clk);
    tests_run++;
    if (outs !== '0) begin tests_failed++; $display("FAIL midload_reset outs=%h exp=0", outs); end
    rst = 1'b0; bus.i_vec_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      tests_failed++; $display("FAIL midload_after busy=%b done=%b exp 0 0", bus.o_busy, bus.o_done);
    end
  endtask

  task automatic test_basic;
    run_job(4, 11'h100, 0, 0, 0, 200);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL basic_timeout got=1 exp=0"); end
    tests_run++;
    if (nw != 12 || first_cnt != 1 || first_idx != 0 || last_cnt != 1 || last_idx != 11) begin
      tests_failed++; $display("FAIL basic_writes nw=%0d first=%0d@%0d last=%0d@%0d exp 12 1@0 1@11", nw, first_cnt, first_idx, last_cnt, last_idx);
    end
    tests_run++;
    if (pause_cnt != 0) begin tests_failed++; $display("FAIL basic_pause got=%0d exp=0", pause_cnt); end
    tests_run++;
    if (wr_lo[5] !== word(5)[63:0] || wr_hi[5] !== word(5)[127:64]) begin
      tests_failed++; $display("FAIL basic_data lo=%h hi=%h exp %h %h", wr_lo[5], wr_hi[5], word(5)[63:0], word(5)[127:64]);
    end
    tests_run++;
    if (first_rd_cyc - last_cyc != LOAD_GAP + 1) begin
      tests_failed++; $display("FAIL basic_gap got=%0d exp=%0d", first_rd_cyc - last_cyc, LOAD_GAP + 1);
    end
    tests_run++;
    if (nrd != 8 || rd_cyc[7] - rd_cyc[0] != 7) begin
      tests_failed++; $display("FAIL basic_reads n=%0d span=%0d exp 8 7", nrd, rd_cyc[7] - rd_cyc[0]);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rd_addr[i] !== 11'h100 + 11'(i)) begin
        tests_failed++; $display("FAIL basic_addr%0d got=%h exp=%h", i, rd_addr[i], 11'h100 + 11'(i));
      end
    end
    tests_run++;
    if (npop != 4 || popped[0] !== exp_sum(0) || popped[3] !== exp_sum(3) || done_cnt != 1) begin
      tests_failed++; $display("FAIL basic_results n=%0d r0=%h r3=%h done=%0d exp 4 %h %h 1", npop, popped[0], popped[3], done_cnt, exp_sum(0), exp_sum(3));
    end
  endtask

  task automatic test_pause;
    run_job(4, 11'h200, 1, 0, 0, 300);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL pause_timeout got=1 exp=0"); end
    tests_run++;
    if (pause_cnt != 2 * (NW - 1) || hold_bad) begin
      tests_failed++; $display("FAIL pause_count got=%0d hold_bad=%0d exp=%0d 0", pause_cnt, hold_bad, 2 * (NW - 1));
    end
    tests_run++;
    if (nw != 12 || first_idx != 0 || last_idx != 11 || first_cnt != 1 || last_cnt != 1) begin
      tests_failed++; $display("FAIL pause_firstlast nw=%0d first@%0d last@%0d exp 12 0 11", nw, first_idx, last_idx);
    end
    tests_run++;
    if (npop != 4 || popped[2] !== exp_sum(2)) begin
      tests_failed++; $display("FAIL pause_results n=%0d r2=%h exp 4 %h", npop, popped[2], exp_sum(2));
    end
  endtask

  task automatic test_credit_stall;
    bit order_bad;
    run_job(10, 11'h000, 0, 80, 0, 400);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL stall_timeout got=1 exp=0"); end
    tests_run++;
    if (reads_before != 2 * FDEPTH) begin
      tests_failed++; $display("FAIL stall_rows_before_ready got=%0d reads exp=%0d", reads_before, 2 * FDEPTH);
    end
    tests_run++;
    if (nrd != 20) begin tests_failed++; $display("FAIL stall_total_reads got=%0d exp=20", nrd); end
    order_bad = 0;
    for (int i = 0; i < 10; i++) if (popped[i] !== exp_sum(i)) order_bad = 1;
    tests_run++;
    if (npop != 10 || order_bad) begin
      tests_failed++; $display("FAIL stall_pop_order n=%0d bad=%0d exp 10 0", npop, order_bad);
    end
    tests_run++;
    if (err_seen) begin tests_failed++; $display("FAIL stall_err got=1 exp=0"); end
  endtask

  task automatic test_zero_rows;
    bit activity;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_num_rows = '0; bus.i_bram_base = 11'h010;
    @(negedge clk);
    bus.i_start = 1'b0;
    tests_run++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL zero_done done=%b busy=%b exp 1 0", bus.o_done, bus.o_busy);
    end
    activity = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_vec_ready || bus.o_read || bus.o_done || bus.o_busy) activity = 1;
    end
    tests_run++;
    if (activity) begin tests_failed++; $display("FAIL zero_activity got=1 exp=0"); end
  endtask

  task automatic test_start_in_compute;
    bit activity;
    run_job(4, 11'h300, 0, 0, 1, 200);
    tests_run++;
    if (timed_out || !poked || nrd != 8 || npop != 4 || done_cnt != 1) begin
      tests_failed++; $display("FAIL ign_start to=%0d poked=%0d reads=%0d pops=%0d done=%0d exp 0 1 8 4 1", timed_out, poked, nrd, npop, done_cnt);
    end
    activity = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_busy || bus.o_read || bus.o_vec_ready) activity = 1;
    end
    tests_run++;
    if (activity) begin tests_failed++; $display("FAIL ign_start_after got=1 exp=0"); end
  endtask

  task automatic test_stray_valid;
    model_en = 0;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_sum = 48'h0000_DEAD_BEEF;
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_sum = '0;
    tests_run++;
    if (bus.o_err !== 1'b1 || bus.o_res_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL stray_err err=%b resv=%b busy=%b exp 1 0 0", bus.o_err, bus.o_res_valid, bus.o_busy);
    end
    model_en = 1;
    run_job(2, 11'h7FF, 0, 0, 0, 200);
    tests_run++;
    if (err_at_start !== 1'b0 || err_seen) begin
      tests_failed++; $display("FAIL stray_clear at_start=%b seen=%b exp 0 0", err_at_start, err_seen);
    end
    tests_run++;
    if (nrd != 4 || rd_addr[0] !== 11'h7FF || rd_addr[1] !== 11'h000 || rd_addr[3] !== 11'h002) begin
      tests_failed++; $display("FAIL wrap_addr n=%0d a0=%h a1=%h a3=%h exp 4 7ff 000 002", nrd, rd_addr[0], rd_addr[1], rd_addr[3]);
    end
    tests_run++;
    if (timed_out || npop != 2 || popped[1] !== exp_sum(1)) begin
      tests_failed++; $display("FAIL wrap_results to=%0d n=%0d r1=%h exp 0 2 %h", timed_out, npop, popped[1], exp_sum(1));
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    model_en = 1; model_row = 0; rd_half = 0;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_num_rows = '0; bus.i_bram_base = '0;
    bus.i_vec_data = '0; bus.i_vec_valid = 1'b0; bus.i_sum = '0;
    bus.i_valid = 1'b0; bus.i_res_ready = 1'b0;
    test_reset();
    test_reset_mid_load();
    test_basic();
    test_pause();
    test_credit_stall();
    test_zero_rows();
    test_start_in_compute();
    test_stray_valid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
